ifetch_resp: RTL and testbench
==============================

Name: ifetch_resp

Overview:
Instruction-side responder that sits between the PC stage and a multi-cycle instruction memory. It consumes the fetch address and enable each cycle and issues a level-held request/acknowledge transaction to memory. It returns the fetched word to the IF/ID boundary and raises a stall request toward the PC stage and pipeline controller until the word is delivered. Branch/exception flushes discard in-flight fetches.

Parameters:
ADDR_W, 32, fetch address width
DATA_W, 32, instruction word width
MAX_WAIT, 15, wait-cycle limit before a fetch is declared failed (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pc_i  in  ADDR_W  fetch address from PC stage
ce_i  in  1  fetch enable from PC stage
flush_i  in  1  discard current/in-flight fetch (taken branch, exception)
stall_i  in  1  downstream IF/ID held; keep delivered word
mem_req_o  out  1  memory request, level-held until ack
mem_addr_o  out  ADDR_W  registered request address
mem_rdata_i  in  DATA_W  memory read data, valid with ack
mem_ack_i  in  1  memory acknowledge, single-cycle pulse
inst_o  out  DATA_W  fetched instruction
inst_valid_o  out  1  inst_o valid this cycle
stallreq_o  out  1  stall request to pipeline control (drives stall[0] source)
fetch_err_o  out  1  one-cycle pulse on misaligned fetch (and timeout if enabled)

Behaviour:
- Reset: state IDLE; mem_req_o=0, mem_addr_o=0, inst_o=0, inst_valid_o=0, fetch_err_o=0, wait counter=0. Reset mid-transaction abandons the request; acks arriving in IDLE are ignored.
- States: IDLE, REQ, DONE, DISCARD.
- IDLE: if ce_i && !flush_i && pc_i[1:0]==0: mem_addr_o<=pc_i, mem_req_o<=1, go REQ. If ce_i && !flush_i && pc_i[1:0]!=0: no memory request; inst_o<=0 (NOP), fetch_err_o pulses, inst_valid_o<=1, go DONE. Otherwise stay.
- REQ: mem_req_o and mem_addr_o held stable. On mem_ack_i && !flush_i: inst_o<=mem_rdata_i, inst_valid_o<=1, mem_req_o<=0, go DONE. On flush_i && mem_ack_i: mem_req_o<=0, drop data, go IDLE. On flush_i && !mem_ack_i: go DISCARD, with mem_req_o still held.
- DISCARD: mem_req_o held until mem_ack_i, then data is dropped, mem_req_o<=0, go IDLE. A further flush_i has no extra effect.
- DONE: inst_valid_o=1, inst_o stable. If flush_i: inst_valid_o<=0, go IDLE. Else if !stall_i: inst_valid_o<=0, go IDLE. Else hold.
- stallreq_o is combinational: 1 when (IDLE && ce_i) or REQ or DISCARD; 0 in DONE. The PC stage therefore advances exactly at the end of DONE.
- Minimum fetch: IDLE, REQ (ack in first cycle), DONE = 3 cycles per instruction. Each added wait cycle adds one.
- ce_i low in REQ does not cancel; only flush_i cancels.
- Exactly one outstanding memory request at any time.

Optional Feature:
IFETCH_TIMEOUT_EN: when defined, a wait counter increments each cycle in REQ/DISCARD and clears on leaving them. In REQ, reaching MAX_WAIT forces mem_req_o<=0, inst_o<=0, inst_valid_o<=1, fetch_err_o pulse, and a move to DONE. In DISCARD, reaching it forces a move to IDLE with no error. When not defined, there is no counter and the block waits indefinitely for ack.

Decomposition:
- Shared defines: state encodings (IF_IDLE, IF_REQ, IF_DONE, IF_DISCARD), NopInst 32'h0, ZeroWord, existing Stop/NoStop and ReadEnable constants.
- Optional sub-module ifetch_wait_timer (counter, clear, limit compare), instantiated only under IFETCH_TIMEOUT_EN.

Test Plan:
- pc_i=0x0000_0000, ce_i=1, ack 2 cycles after req with rdata=0x2408_0005 -> mem_req_o high 2 cycles, inst_o=0x2408_0005 with inst_valid_o for 1 cycle, stallreq_o low only in DONE.
- Back-to-back pc 0x0,0x4,0x8 with ack on first REQ cycle -> three instructions delivered in order, 3 cycles each.
- flush_i in REQ with ack 3 cycles later -> DISCARD, rdata not delivered, inst_valid_o stays 0, next fetch addr = new pc_i.
- flush_i coincident with ack -> IDLE directly, no valid, mem_req_o low next cycle.
- stall_i=1 for 4 cycles in DONE -> inst_o/inst_valid_o held 5 cycles, no new mem_req_o.
- pc_i=0x0000_0002 -> no mem_req_o, fetch_err_o one pulse, inst_o=0. With IFETCH_TIMEOUT_EN and no ack for 15 cycles -> fetch_err_o pulse, inst_o=0, mem_req_o dropped.

Source files
------------

// File: rtl/ifetch_resp_pkg.sv
// Shared encodings and constants for the instruction-fetch responder.
package ifetch_resp_pkg;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'b00,
        IF_REQ     = 2'b01,
        IF_DONE    = 2'b10,
        IF_DISCARD = 2'b11
    } if_state_e;

    localparam logic [31:0] NopInst     = 32'h0000_0000;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        Stop        = 1'b1;
    localparam logic        NoStop      = 1'b0;
    localparam logic        ReadEnable  = 1'b1;
    localparam logic        ReadDisable = 1'b0;

    // Instruction fetches must be word aligned.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_wait_timer.sv
// Wait-cycle counter for ifetch_resp; only instantiated when IFETCH_TIMEOUT_EN is defined.
module ifetch_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic limit
);
    localparam int CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] cnt_r;

    // Count cycles while enabled, clear otherwise; saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CntW{1'b0}};
        end else if (!en) begin
            cnt_r <= {CntW{1'b0}};
        end else if (cnt_r != CntW'(MAX_WAIT - 1)) begin
            cnt_r <= cnt_r + {{(CntW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Limit is seen during the MAX_WAIT-th waiting cycle.
    always_comb begin
        if (en && (cnt_r == CntW'(MAX_WAIT - 1))) begin
            limit = 1'b1;
        end else begin
            limit = 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: PC-stage request to multi-cycle memory, word to IF/ID.
// Optional fetch timeout enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_resp
    import ifetch_resp_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stallreq_o,
    output logic              fetch_err_o
);

    if_state_e state_r;

`ifdef IFETCH_TIMEOUT_EN
    logic wait_en_s;
    logic wait_limit_s;

    assign wait_en_s = (state_r == IF_REQ) || (state_r == IF_DISCARD);

    ifetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (wait_en_s),
        .limit (wait_limit_s)
    );
`else
    localparam logic [31:0] MaxWaitVec = 32'(MAX_WAIT);
    logic unused_s;
    assign unused_s = ^MaxWaitVec;
`endif

    // Fetch sequencer: one outstanding request, flush drops data still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IF_IDLE;
            mem_req_o    <= ReadDisable;
            mem_addr_o   <= ADDR_W'(ZeroWord);
            inst_o       <= DATA_W'(NopInst);
            inst_valid_o <= 1'b0;
            fetch_err_o  <= 1'b0;
        end else begin
            fetch_err_o <= 1'b0;
            case (state_r)
                IF_IDLE: begin
                    if (ce_i && !flush_i) begin
                        if (is_word_aligned(pc_i[1:0])) begin
                            mem_addr_o <= pc_i;
                            mem_req_o  <= ReadEnable;
                            state_r    <= IF_REQ;
                        end else begin
                            inst_o       <= DATA_W'(NopInst);
                            inst_valid_o <= 1'b1;
                            fetch_err_o  <= 1'b1;
                            state_r      <= IF_DONE;
                        end
                    end else begin
                        state_r <= IF_IDLE;
                    end
                end
                IF_REQ: begin
                    if (mem_ack_i && !flush_i) begin
                        inst_o       <= mem_rdata_i;
                        inst_valid_o <= 1'b1;
                        mem_req_o    <= ReadDisable;
                        state_r      <= IF_DONE;
                    end else if (mem_ack_i) begin
                        mem_req_o <= ReadDisable;
                        state_r   <= IF_IDLE;
                    end else if (flush_i) begin
                        state_r <= IF_DISCARD;
`ifdef IFETCH_TIMEOUT_EN
                    end else if (wait_limit_s) begin
                        mem_req_o    <= ReadDisable;
                        inst_o       <= DATA_W'(NopInst);
                        inst_valid_o <= 1'b1;
                        fetch_err_o  <= 1'b1;
                        state_r      <= IF_DONE;
`endif
                    end else begin
                        state_r <= IF_REQ;
                    end
                end
                IF_DISCARD: begin
                    if (mem_ack_i) begin
                        mem_req_o <= ReadDisable;
                        state_r   <= IF_IDLE;
`ifdef IFETCH_TIMEOUT_EN
                    end else if (wait_limit_s) begin
                        mem_req_o <= ReadDisable;
                        state_r   <= IF_IDLE;
`endif
                    end else begin
                        state_r <= IF_DISCARD;
                    end
                end
                IF_DONE: begin
                    if (flush_i || !stall_i) begin
                        inst_valid_o <= 1'b0;
                        state_r      <= IF_IDLE;
                    end else begin
                        state_r <= IF_DONE;
                    end
                end
                default: begin
                    mem_req_o    <= ReadDisable;
                    inst_valid_o <= 1'b0;
                    state_r      <= IF_IDLE;
                end
            endcase
        end
    end

    // PC stage may only advance while the word sits in DONE.
    always_comb begin
        stallreq_o = NoStop;
        case (state_r)
            IF_IDLE: begin
                if (ce_i) begin
                    stallreq_o = Stop;
                end else begin
                    stallreq_o = NoStop;
                end
            end
            IF_REQ:     stallreq_o = Stop;
            IF_DISCARD: stallreq_o = Stop;
            IF_DONE:    stallreq_o = NoStop;
            default:    stallreq_o = NoStop;
        endcase
    end

endmodule

// File: tb/tb_ifetch_resp.sv
// Scoreboard bench for ifetch_resp (default build, no timeout feature).
module tb_ifetch_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        flush_i;
    logic        stall_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stallreq_o;
    logic        fetch_err_o;

    ifetch_resp dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stallreq_o   (stallreq_o),
        .fetch_err_o  (fetch_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   done_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every new delivery pops one expected word.
    initial begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid_o && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery", inst_o, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_inst", inst_o, e.inst);
                    chk("mon_err", {31'd0, fetch_err_o}, {31'd0, e.err});
                    chk("mon_stallreq_done", {31'd0, stallreq_o}, 32'd0);
                end
            end
            prev_valid = rst ? 1'b0 : inst_valid_o;
        end
    end

    // Issue an aligned fetch; ack after nwait extra REQ cycles; returns in the DONE cycle.
    task automatic fetch(input logic [31:0] addr, input int nwait, input logic [31:0] data);
        bit   seen;
        exp_t e;
        pc_i = addr;
        ce_i = 1'b1;
        e.inst = data;
        e.err  = 1'b0;
        exp_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_req_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("req_timeout", 32'd0, 32'd1);
            return;
        end
        chk("req_addr", mem_addr_o, addr);
        chk("req_stallreq", {31'd0, stallreq_o}, 32'd1);
        for (int i = 0; i < nwait; i++) begin
            step();
            chk("req_held", {31'd0, mem_req_o}, 32'd1);
            chk("req_addr_held", mem_addr_o, addr);
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = data;
        step();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hFFFF_FFFF;
        done_t = cyc;
        chk("done_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("done_valid", {31'd0, inst_valid_o}, 32'd1);
    endtask

    initial begin : stimulus
        int   t0;
        int   t1;
        exp_t e;
        rst = 1'b1; pc_i = 32'd0; ce_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0000_0000;
        step(); step();
        rst = 1'b0;
        // Ack in IDLE must be ignored.
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_err", {31'd0, fetch_err_o}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);

        // Single fetch, ack in the second REQ cycle; valid for one cycle.
        ce_i = 1'b1;
        #1;
        chk("idle_ce_stallreq", {31'd0, stallreq_o}, 32'd1);
        fetch(32'h0000_0000, 1, 32'h2408_0005);
        ce_i = 1'b0;
        step();
        chk("t1_valid_drop", {31'd0, inst_valid_o}, 32'd0);
        chk("t1_no_req", {31'd0, mem_req_o}, 32'd0);

        // Back-to-back fetches, three cycles apart.
        fetch(32'h0000_0000, 0, 32'h2001_0001);
        t0 = done_t;
        fetch(32'h0000_0004, 0, 32'h2002_0002);
        chk("b2b_period1", done_t - t0, 32'd3);
        t1 = done_t;
        fetch(32'h0000_0008, 0, 32'h0022_1820);
        chk("b2b_period2", done_t - t1, 32'd3);
        ce_i = 1'b0;
        step();

        // Flush in REQ, ack arrives three cycles later and is dropped.
        pc_i = 32'h0000_0100; ce_i = 1'b1;
        step();
        chk("fl_req", {31'd0, mem_req_o}, 32'd1);
        flush_i = 1'b1;
        pc_i = 32'h0000_0200;
        step();
        flush_i = 1'b0;
        chk("disc_req_held", {31'd0, mem_req_o}, 32'd1);
        chk("disc_stallreq", {31'd0, stallreq_o}, 32'd1);
        step();
        chk("disc_no_valid", {31'd0, inst_valid_o}, 32'd0);
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        step();
        mem_ack_i = 1'b0;
        chk("disc_req_drop", {31'd0, mem_req_o}, 32'd0);
        chk("disc_valid_low", {31'd0, inst_valid_o}, 32'd0);
        fetch(32'h0000_0200, 0, 32'h1111_0000);
        ce_i = 1'b0;
        step();

        // Flush coincident with ack: straight back to IDLE.
        pc_i = 32'h0000_0300; ce_i = 1'b1;
        step();
        chk("flack_req", {31'd0, mem_req_o}, 32'd1);
        flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_0BAD; ce_i = 1'b0;
        step();
        flush_i = 1'b0; mem_ack_i = 1'b0;
        chk("flack_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("flack_no_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("flack_idle_stallreq", {31'd0, stallreq_o}, 32'd0);
        step();
        chk("flack_stay_idle", {31'd0, mem_req_o}, 32'd0);

        // Stall held four cycles in DONE: word held five cycles.
        fetch(32'h0000_0400, 0, 32'h8C01_0004);
        stall_i = 1'b1; ce_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("stall_inst", inst_o, 32'h8C01_0004);
            chk("stall_no_req", {31'd0, mem_req_o}, 32'd0);
            step();
        end
        chk("stall_valid5", {31'd0, inst_valid_o}, 32'd1);
        chk("stall_inst5", inst_o, 32'h8C01_0004);
        stall_i = 1'b0;
        step();
        chk("stall_release", {31'd0, inst_valid_o}, 32'd0);
        chk("stall_release_req", {31'd0, mem_req_o}, 32'd0);

        // Misaligned fetch: NOP with a single error pulse, no memory request.
        e.inst = 32'h0000_0000; e.err = 1'b1;
        exp_q.push_back(e);
        pc_i = 32'h0000_0002; ce_i = 1'b1;
        step();
        ce_i = 1'b0;
        chk("mis_no_req", {31'd0, mem_req_o}, 32'd0);
        chk("mis_err", {31'd0, fetch_err_o}, 32'd1);
        chk("mis_inst", inst_o, 32'd0);
        chk("mis_valid", {31'd0, inst_valid_o}, 32'd1);
        step();
        chk("mis_err_pulse", {31'd0, fetch_err_o}, 32'd0);
        chk("mis_valid_drop", {31'd0, inst_valid_o}, 32'd0);
        chk("mis_no_req2", {31'd0, mem_req_o}, 32'd0);

        step(); step();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
